hidden_forward: RTL and testbench
=================================

Name: hidden_forward

Overview:
Forward-pass engine for the 4-input, single-hidden-neuron network. It computes the hidden activation and the network output, which the weight-update stage consumes as hidden_val and final.
- Uses a serial multiply-accumulate: one input per cycle, followed by one output-multiply cycle.
- Holds the live weight set. Weights are reloaded from the weight-update stage after each backprop step, or zeroed on request.

Parameters:
INIT_W, 8'd1, reset value of each hidden weight register w0..w3
INIT_WOUT, 9'd1, reset value of the output weight register

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  request a forward pass; sampled only in IDLE
x_i  in  4  binary input vector; bit k gates weight k
wload_i  in  1  load w0_i..w3_i and wout_i into the weight registers
w0_i  in  8  new hidden weight 0 (unsigned)
w1_i  in  8  new hidden weight 1 (unsigned)
w2_i  in  8  new hidden weight 2 (unsigned)
w3_i  in  8  new hidden weight 3 (unsigned)
wout_i  in  9  new output weight (unsigned)
zero_weight_reset_i  in  1  clear all weight registers to 0
hidden_val_o  out  10  hidden activation of the last completed pass
final_o  out  19  network output of the last completed pass
busy_o  out  1  high in ACC and MUL states
done_o  out  1  one-cycle pulse when the outputs are updated

Behaviour:
- Reset (rst_i=1 at an edge):
  - State goes to IDLE; accumulator and index are cleared.
  - hidden_val_o=0, final_o=0, busy_o=0, done_o=0.
  - w0..w3=INIT_W, wout=INIT_WOUT.
  - Reset overrides every other input, including mid-pass; an aborted pass produces no done_o.
- Weight registers (independent of FSM state):
  - zero_weight_reset_i=1 clears all five registers. It has priority over wload_i.
  - Otherwise, wload_i=1 loads all five registers from the port values.
  - Loads never disturb a pass in progress: the pass uses a snapshot taken at start.
- Snapshot rule:
  - When start_i is accepted, x_i and the weights are copied to working registers.
  - If wload_i or zero_weight_reset_i is also asserted that cycle, the snapshot takes the newly written values (bypass).
- FSM states: IDLE, ACC, MUL, DONE.
  - IDLE: if start_i=1 at edge N: take the snapshot, clear acc (10 bit), set idx=0, go to ACC.
  - ACC: each edge, acc += xs[idx] ? ws[idx] : 0, then idx++. After the idx=3 edge (edge N+4), go to MUL.
  - MUL, at edge N+5:
    - hidden_val_o <= acc.
    - final_o <= acc * wouts, a 10x9 unsigned product, exactly 19 bits.
    - done_o <= 1; go to DONE.
  - DONE: at edge N+6, done_o <= 0 and go to IDLE. A start_i accepted in IDLE at edge N+7 or later begins a new pass.
- Timing:
  - done_o is high for exactly the one cycle between edges N+5 and N+6.
  - Minimum start-to-start spacing is 7 cycles.
- Widths: maximum acc is 4*255=1020, which fits 10 bits. Maximum final is 1020*511=521220 < 2^19. No saturation or truncation anywhere.
- busy_o=1 in ACC and MUL; 0 in IDLE and DONE. start_i outside IDLE is ignored and not queued.
- Output hold: hidden_val_o and final_o hold their values between passes. They change only at the MUL edge or on reset.
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
1. Reset release, then weights loaded 10,20,30,40 with wout=3. Start with x=4'b1011 -> done_o pulses 6 cycles after start is accepted; hidden_val_o=70, final_o=210; busy_o high for cycles 1..5.
2. All weights 255, wout=511, x=4'b1111 -> hidden_val_o=1020, final_o=521220; x=4'b0000 on the next pass -> 0, 0.
3. start_i held high continuously with default weights (INIT_W=1, INIT_WOUT=1) and x=4'b0110 -> a pass completes every 7 cycles, each giving hidden=2, final=2; no extra pulses from starts while busy.
4. wload_i during ACC with new weights 100 -> current pass uses the old snapshot; the next pass uses 100s. Then start with wload_i in the same cycle -> snapshot uses the new values.
5. rst_i asserted at ACC idx=2 -> no done_o, outputs=0, state IDLE, weights=INIT values. zero_weight_reset_i with wload_i together -> weights read back 0, so the next pass gives final_o=0.

Source files
------------

// File: rtl/hidden_forward.sv
// -----------------------------------------------------------------------------
// hidden_forward
//
// Forward-pass engine for a 4-input, single-hidden-neuron network.
//   hidden = sum over k of (x[k] ? w[k] : 0)  (10-bit, serial, one input/cycle)
//   final  = hidden * wout                    (10x9 unsigned -> 19-bit)
//
// Holds the live weight set (w0..w3, wout). The weight-update stage reloads it
// after each backprop step with wload_i, or clears it with zero_weight_reset_i.
// A pass works on a snapshot of x_i and the weights taken when start_i is
// accepted, so weight traffic never disturbs a pass in flight.
//
// Ports:
//   clk_i               clock, all state changes on the rising edge
//   rst_i               synchronous reset, active-high
//   start_i             request a pass; only sampled in IDLE
//   x_i[3:0]            binary input vector; bit k gates weight k
//   wload_i             load w0_i..w3_i and wout_i into the weight registers
//   w0_i..w3_i[7:0]     new hidden weights (unsigned)
//   wout_i[8:0]         new output weight (unsigned)
//   zero_weight_reset_i clear all weight registers (wins over wload_i)
//   hidden_val_o[9:0]   hidden activation of the last completed pass
//   final_o[18:0]       network output of the last completed pass
//   busy_o              high while in ACC or MUL
//   done_o              one-cycle pulse when the outputs are updated
//
// Timing (start accepted at edge N): ACC at edges N+1..N+4, MUL at N+5
// (outputs written, done_o rises), DONE at N+6, next start accepted at N+7.
// -----------------------------------------------------------------------------
module hidden_forward #(
  parameter logic [7:0] INIT_W    = 8'd1,
  parameter logic [8:0] INIT_WOUT = 9'd1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  x_i,
  input  logic        wload_i,
  input  logic [7:0]  w0_i,
  input  logic [7:0]  w1_i,
  input  logic [7:0]  w2_i,
  input  logic [7:0]  w3_i,
  input  logic [8:0]  wout_i,
  input  logic        zero_weight_reset_i,
  output logic [9:0]  hidden_val_o,
  output logic [18:0] final_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;

  // Live weight set and its next value.
  logic [7:0] w_q    [4];
  logic [8:0] wout_q;
  logic [7:0] w_nxt  [4];
  logic [8:0] wout_nxt;

  // Working snapshot used by the pass in progress.
  logic [3:0] xs;
  logic [7:0] ws     [4];
  logic [8:0] wouts;

  logic [1:0] idx;
  logic [9:0] acc;
  logic [9:0] addend;
  logic [18:0] product;
  logic        start_acc;

  assign start_acc = (state == IDLE) && start_i;

  // ---------------------------------------------------------------------------
  // Next weight value. The snapshot also reads w_nxt, which gives the bypass:
  // a load or clear in the same cycle as an accepted start is seen by that pass.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    w_nxt    = w_q;
    wout_nxt = wout_q;
    if (zero_weight_reset_i) begin
      for (int k = 0; k < 4; k++) w_nxt[k] = '0;
      wout_nxt = '0;
    end else if (wload_i) begin
      w_nxt[0] = w0_i;
      w_nxt[1] = w1_i;
      w_nxt[2] = w2_i;
      w_nxt[3] = w3_i;
      wout_nxt = wout_i;
    end
  end

  // Weight registers run independently of the FSM.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst_i) begin
      for (int k = 0; k < 4; k++) w_q[k] <= INIT_W;
      wout_q <= INIT_WOUT;
    end else begin
      w_q    <= w_nxt;
      wout_q <= wout_nxt;
    end
  end

  // NOTE: the snapshot has no reset; it is always written when a pass starts,
  // before the ACC/MUL states ever read it.
  always_ff @(posedge clk_i) begin
    if (start_acc) begin
      xs    <= x_i;
      ws    <= w_nxt;
      wouts <= wout_nxt;
    end
  end

  // One serial MAC term: the weight selected by idx, gated by its input bit.
  assign addend  = xs[idx] ? {2'b00, ws[idx]} : 10'd0;

  // Full-width product; both operands widened to 19 bits, no truncation.
  assign product = {9'd0, acc} * {10'd0, wouts};

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      acc          <= '0;
      idx          <= '0;
      hidden_val_o <= '0;
      final_o      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            acc    <= '0;
            idx    <= '0;
            busy_o <= 1'b1;
            state  <= ACC;
          end
        end
        ACC: begin
          acc <= acc + addend;
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= MUL;
        end
        MUL: begin
          hidden_val_o <= acc;
          final_o      <= product;
          done_o       <= 1'b1;
          busy_o       <= 1'b0;
          state        <= DONE;
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_forward.sv
// -----------------------------------------------------------------------------
// tb_hidden_forward
//
// Self-checking bench for hidden_forward. Expected results are pushed to a
// scoreboard queue when a pass is started and popped by a monitor on done_o.
// Passes come from a vector table plus hand-written sequences for held start,
// mid-pass weight loads, start/load bypass, mid-pass reset and zeroing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hidden_forward;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  x_i;
  logic        wload_i;
  logic [7:0]  w0_i, w1_i, w2_i, w3_i;
  logic [8:0]  wout_i;
  logic        zero_weight_reset_i;
  logic [9:0]  hidden_val_o;
  logic [18:0] final_o;
  logic        busy_o;
  logic        done_o;

  hidden_forward #(.INIT_W(8'd1), .INIT_WOUT(9'd1)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .start_i             (start_i),
    .x_i                 (x_i),
    .wload_i             (wload_i),
    .w0_i                (w0_i),
    .w1_i                (w1_i),
    .w2_i                (w2_i),
    .w3_i                (w3_i),
    .wout_i              (wout_i),
    .zero_weight_reset_i (zero_weight_reset_i),
    .hidden_val_o        (hidden_val_o),
    .final_o             (final_o),
    .busy_o              (busy_o),
    .done_o              (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [9:0]  h;
    logic [18:0] f;
  } exp_t;

  typedef struct {
    logic [7:0]  w [4];
    logic [8:0]  wout;
    logic [3:0]  x;
    logic [9:0]  h;
    logic [18:0] f;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    sb.delete();
  endtask

  task automatic load_weights(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d,
                              input logic [8:0] o);
    w0_i = a; w1_i = b; w2_i = c; w3_i = d; wout_i = o;
    wload_i = 1'b1;
    tick();
    wload_i = 1'b0;
  endtask

  // Start one pass from IDLE and follow it to edge N+6. busy_o must be high
  // after edges N..N+4 and done_o only after N+5. If load_at >= 0, wload_i is
  // pulsed for one cycle after edge N+load_at using the current port values.
  task automatic run_pass(input logic [3:0] x, input logic [9:0] eh,
                          input logic [18:0] ef, input int load_at);
    int bad;
    bad = 0;
    x_i = x;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wload_i = 1'b0;
    zero_weight_reset_i = 1'b0;
    sb.push_back('{h: eh, f: ef});
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      if (busy_o !== (k <= 4) || done_o !== (k == 5)) bad++;
      wload_i = (k == load_at);
    end
    wload_i = 1'b0;
    check("pass_timing", bad, 0);
  endtask

  // Monitor: every done_o pulse must match the oldest expected result.
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      if (done_o === 1'b1) begin
        done_cnt++;
        check("done_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("hidden_val", hidden_val_o, mon_e.h);
          check("final_val", final_o, mon_e.f);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t vecs [5];

  initial begin
    int bad;
    int d0;

    vecs[0] = '{w: '{8'd10,  8'd20,  8'd30,  8'd40 }, wout: 9'd3,   x: 4'b1011, h: 10'd70,   f: 19'd210};
    vecs[1] = '{w: '{8'd255, 8'd255, 8'd255, 8'd255}, wout: 9'd511, x: 4'b1111, h: 10'd1020, f: 19'd521220};
    vecs[2] = '{w: '{8'd255, 8'd255, 8'd255, 8'd255}, wout: 9'd511, x: 4'b0000, h: 10'd0,    f: 19'd0};
    vecs[3] = '{w: '{8'd1,   8'd2,   8'd4,   8'd8  }, wout: 9'd511, x: 4'b0101, h: 10'd5,    f: 19'd2555};
    vecs[4] = '{w: '{8'd200, 8'd0,   8'd50,  8'd7  }, wout: 9'd300, x: 4'b1110, h: 10'd57,   f: 19'd17100};

    start_i = 1'b0; x_i = '0; wload_i = 1'b0; zero_weight_reset_i = 1'b0;
    w0_i = '0; w1_i = '0; w2_i = '0; w3_i = '0; wout_i = '0;
    rst_i = 1'b1;

    // Reset state.
    do_reset();
    check("rst_hidden", hidden_val_o, 0);
    check("rst_final", final_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);

    // Table-driven passes.
    for (int i = 0; i < 5; i++) begin
      load_weights(vecs[i].w[0], vecs[i].w[1], vecs[i].w[2], vecs[i].w[3], vecs[i].wout);
      run_pass(vecs[i].x, vecs[i].h, vecs[i].f, -1);
      check("hold_hidden", hidden_val_o, vecs[i].h);
    end

    // start_i held high with default weights: one pass every 7 cycles.
    do_reset();
    x_i = 4'b0110;
    start_i = 1'b1;
    bad = 0;
    d0 = done_cnt;
    for (int e = 0; e <= 21; e++) begin
      tick();
      if (e == 0 || e == 7 || e == 14) sb.push_back('{h: 10'd2, f: 19'd2});
      if (done_o !== (e == 5 || e == 12 || e == 19)) bad++;
      if (busy_o !== ((e % 7) <= 4 && e <= 18)) bad++;
      if (e == 14) start_i = 1'b0;
    end
    check("held_start_timing", bad, 0);
    check("held_start_count", done_cnt - d0, 3);

    // Load during ACC: current pass keeps its snapshot, next pass sees 100s.
    load_weights(8'd1, 8'd2, 8'd3, 8'd4, 9'd5);
    w0_i = 8'd100; w1_i = 8'd100; w2_i = 8'd100; w3_i = 8'd100; wout_i = 9'd100;
    run_pass(4'b1111, 10'd10, 19'd50, 1);
    run_pass(4'b1111, 10'd400, 19'd40000, -1);

    // Load in the same cycle as start: the snapshot takes the new values.
    w0_i = 8'd7; w1_i = 8'd8; w2_i = 8'd9; w3_i = 8'd10; wout_i = 9'd2;
    wload_i = 1'b1;
    run_pass(4'b1111, 10'd34, 19'd68, -1);

    // Reset in ACC with idx=2 aborts the pass.
    load_weights(8'd10, 8'd20, 8'd30, 8'd40, 9'd3);
    run_pass(4'b1111, 10'd100, 19'd300, -1);
    x_i = 4'b1111;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("abort_hidden", hidden_val_o, 0);
    check("abort_final", final_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    d0 = done_cnt;
    repeat (8) tick();
    check("abort_no_done", done_cnt - d0, 0);
    // Weights are back to INIT values and the FSM accepts a start.
    run_pass(4'b1111, 10'd4, 19'd4, -1);

    // Zero and load together: zero wins.
    w0_i = 8'd50; w1_i = 8'd50; w2_i = 8'd50; w3_i = 8'd50; wout_i = 9'd50;
    wload_i = 1'b1;
    zero_weight_reset_i = 1'b1;
    tick();
    wload_i = 1'b0;
    zero_weight_reset_i = 1'b0;
    check("zero_hold_hidden", hidden_val_o, 4);
    run_pass(4'b1111, 10'd0, 19'd0, -1);

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
